// File: rtl/mod_reduce_256.sv
// Sequential modular reducer: R_Out = C_In mod P, restoring shift-and-subtract,
// one product bit per clock (256 RUN cycles, result 257 cycles after start).
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - synchronous active-high reset
//   C_In     - 2*WIDTH-bit product, sampled on an accepted start
//   In_Busy  - start strobe, honoured in IDLE or DONE, ignored in RUN
//   Out_Busy - registered, high while a reduction is in progress
//   Done     - registered single-cycle pulse, R_Out valid in this cycle
//   R_Out    - registered WIDTH-bit residue, held until the next completion
module mod_reduce_256 #(
    parameter int unsigned    WIDTH = 128,
    parameter logic [WIDTH-1:0] P   = WIDTH'(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   C_In,
    input  logic                 In_Busy,
    output logic                 Out_Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     R_Out
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       sh_q, sh_d;
    logic [WIDTH-1:0]    r_q, r_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    r_out_q, r_out_d;

    // Datapath: T = 2R + next product bit; R < P keeps T inside WIDTH+1 bits.
    // R itself is stored in WIDTH bits because its top bit is always zero.
    logic [WIDTH:0]      t;
    logic                t_ge;
    logic [WIDTH-1:0]    t_sub;
    logic [WIDTH-1:0]    r_next;

    always_comb begin
        t      = {r_q, sh_q[PW-1]};
        t_ge   = (t >= {1'b0, P});
        t_sub  = WIDTH'(t - {1'b0, P});
        r_next = t_ge ? t_sub : t[WIDTH-1:0];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        r_out_d = r_out_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (In_Busy) begin
                    state_d = S_RUN;
                    sh_d    = C_In;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d   = r_next;
                sh_d  = {sh_q[PW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the residue with the Done pulse on the same edge
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    r_out_d = r_next;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_out_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r_out_q <= r_out_d;
        end
    end

    assign Out_Busy = busy_q;
    assign Done     = done_q;
    assign R_Out    = r_out_q;

endmodule

// File: tb/tb_mod_reduce_256.sv
// Self-checking bench for mod_reduce_256: table of known residues, hand-written
// multi-cycle sequences, and random products, all checked through a scoreboard.
module tb_mod_reduce_256;

    localparam int unsigned WIDTH  = 128;
    localparam logic [127:0] P     = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;
    localparam int unsigned N_RAND = 200;
    localparam int unsigned LAT    = 256;

    logic               clk;
    logic               rst;
    logic [255:0]       C_In;
    logic               In_Busy;
    logic               Out_Busy;
    logic               Done;
    logic [127:0]       R_Out;

    mod_reduce_256 #(.WIDTH(WIDTH), .P(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .C_In     (C_In),
        .In_Busy  (In_Busy),
        .Out_Busy (Out_Busy),
        .Done     (Done),
        .R_Out    (R_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] exp;
        int           acc_edge;
    } sb_t;

    typedef struct {
        logic [255:0] c_in;
        logic [127:0] exp;
    } vec_t;

    sb_t  sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: fold with 2^128 = 159 (mod P), then one final conditional subtract
    function automatic logic [127:0] ref_mod(input logic [255:0] c);
        logic [255:0] x;
        x = 256'(c[255:128]) * 256'd159 + 256'(c[127:0]);
        x = 256'(x[255:128]) * 256'd159 + 256'(x[127:0]);
        while (x >= 256'(P)) x = x - 256'(P);
        return x[127:0];
    endfunction

    // Monitor: pop the scoreboard on every Done and check value, range and timing
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (Out_Busy) busy_cnt++;
            if (Done) begin
                sb_t e;
                done_cnt++;
                check("busy_with_done", 256'(Out_Busy), 256'(0));
                if (sb.size() == 0) begin
                    check("unexpected_done", 256'(1), 256'(0));
                end else begin
                    e = sb.pop_front();
                    check("residue", 256'(R_Out), 256'(e.exp));
                    check("residue_lt_p", 256'(R_Out < P), 256'(1));
                    check("latency", 256'(cyc - e.acc_edge), 256'(LAT));
                    check("busy_cycles", 256'(busy_cnt), 256'(LAT));
                end
                busy_cnt = 0;
            end
        end
    end

    // Raise In_Busy for one edge; caller guarantees the DUT is in IDLE or DONE
    task automatic do_start(input logic [255:0] c, input logic [127:0] exp);
        sb_t e;
        C_In    = c;
        In_Busy = 1'b1;
        e.exp      = exp;
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        In_Busy = 1'b0;
    endtask

    // Bounded wait until done_cnt reaches target; returns mid DONE cycle
    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) break;
        end
        if (k == 400) check("done_timeout", 256'(done_cnt), 256'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [255:0] two128;
    logic [255:0] c_rand;
    vec_t         vecs[5];

    initial begin
        int base;
        two128 = 256'd1 << 128;
        vecs[0] = '{c_in: 256'd0,             exp: 128'd0};
        vecs[1] = '{c_in: two128,             exp: 128'h9F};
        vecs[2] = '{c_in: 256'(P),            exp: 128'd0};
        vecs[3] = '{c_in: 256'(P) - 256'd1,   exp: P - 128'd1};
        vecs[4] = '{c_in: {256{1'b1}},        exp: 128'h62C0};

        rst = 1'b1; In_Busy = 1'b0; C_In = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_busy", 256'(Out_Busy), 256'(0));
        check("rst_done",     256'(Done),     256'(0));
        check("rst_r_out",    256'(R_Out),    256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);

        // Known residues from IDLE
        for (int i = 0; i < 5; i++) begin
            do_start(vecs[i].c_in, vecs[i].exp);
            wait_done(done_cnt + 1);
            idle_cycles(2);
        end

        // Start pulse during RUN must be ignored
        base = done_cnt;
        do_start(two128, 128'h9F);
        idle_cycles(99);
        C_In = 256'd5; In_Busy = 1'b1;
        idle_cycles(1);
        In_Busy = 1'b0;
        wait_done(base + 1);
        idle_cycles(300);
        check("single_done", 256'(done_cnt), 256'(base + 1));

        // Back-to-back: In_Busy held high across the DONE cycle
        base = done_cnt;
        C_In = two128; In_Busy = 1'b1;
        sb.push_back('{exp: 128'h9F, acc_edge: cyc + 1});
        idle_cycles(10);
        C_In = 256'(P) + 256'd7;
        sb.push_back('{exp: 128'h7, acc_edge: cyc - 9 + 257});
        wait_done(base + 1);
        @(posedge clk); #1;
        In_Busy = 1'b0;
        wait_done(base + 2);
        idle_cycles(2);

        // Reset in the middle of a run abandons it
        base = done_cnt;
        do_start(two128, 128'h9F);
        idle_cycles(127);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_r_out",    256'(R_Out),    256'(0));
        check("midrst_out_busy", 256'(Out_Busy), 256'(0));
        idle_cycles(300);
        check("midrst_no_done",  256'(done_cnt), 256'(base));
        check("midrst_r_hold",   256'(R_Out),    256'(0));
        do_start(two128, 128'h9F);
        wait_done(base + 1);

        // Random products, alternating back-to-back and from-IDLE starts
        for (int i = 0; i < N_RAND; i++) begin
            c_rand = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 0) idle_cycles(1 + (i % 3));
            do_start(c_rand, ref_mod(c_rand));
            wait_done(done_cnt + 1);
        end
        idle_cycles(5);
        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
